// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl_pkg
// Description : Shared state encodings, NOP encoding and hold bundle type.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

  localparam logic [1:0]  STATE_RUN      = 2'd0;
  localparam logic [1:0]  STATE_MD_WAIT  = 2'd1;
  localparam logic [1:0]  STATE_BUS_WAIT = 2'd2;

  // Instruction loaded by the pipeline registers on flush: ADDI x0,x0,0
  localparam logic [31:0] NOP_INSN       = 32'h0000_0013;

  typedef struct packed {
    logic pc;
    logic if_id;
    logic id_ex;
  } hold_t;

  function automatic hold_t all_hold(input logic en);
    all_hold = '{pc: en, if_id: en, id_ex: en};
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl_if
// Description : Hazard/stall request and control bundle around pipe_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
interface pipe_ctrl_if;

  logic        jump_en_i;
  logic [31:0] jump_addr_i;
  logic [4:0]  id_rs1_addr_i;
  logic [4:0]  id_rs2_addr_i;
  logic        id_rs1_used_i;
  logic        id_rs2_used_i;
  logic        ex_load_i;
  logic [4:0]  ex_rd_addr_i;
  logic        mem_busy_i;
  logic        md_start_i;
  logic        md_done_i;
  logic        hold_pc_o;
  logic        hold_if_id_o;
  logic        hold_id_ex_o;
  logic        flush_if_id_o;
  logic        flush_id_ex_o;
  logic        redirect_en_o;
  logic [31:0] redirect_addr_o;
  logic        bus_err_o;
  logic [1:0]  state_o;

  modport slave (
    input  jump_en_i, jump_addr_i, id_rs1_addr_i, id_rs2_addr_i,
           id_rs1_used_i, id_rs2_used_i, ex_load_i, ex_rd_addr_i,
           mem_busy_i, md_start_i, md_done_i,
    output hold_pc_o, hold_if_id_o, hold_id_ex_o, flush_if_id_o,
           flush_id_ex_o, redirect_en_o, redirect_addr_o, bus_err_o, state_o
  );

  modport master (
    output jump_en_i, jump_addr_i, id_rs1_addr_i, id_rs2_addr_i,
           id_rs1_used_i, id_rs2_used_i, ex_load_i, ex_rd_addr_i,
           mem_busy_i, md_start_i, md_done_i,
    input  hold_pc_o, hold_if_id_o, hold_id_ex_o, flush_if_id_o,
           flush_id_ex_o, redirect_en_o, redirect_addr_o, bus_err_o, state_o
  );

endinterface
`default_nettype wire

// File: rtl/pipe_ctrl_hazard_det.sv
`default_nettype none
// ============================================================================
// Module      : hazard_det
// Description : Combinational load-use comparator between EX and ID.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_det (
  input  logic       ex_load_i,
  input  logic [4:0] ex_rd_addr_i,
  input  logic [4:0] id_rs1_addr_i,
  input  logic [4:0] id_rs2_addr_i,
  input  logic       id_rs1_used_i,
  input  logic       id_rs2_used_i,
  output logic       load_use_o
);

  logic w_rs1_hit;
  logic w_rs2_hit;

  assign w_rs1_hit  = id_rs1_used_i && (id_rs1_addr_i == ex_rd_addr_i);
  assign w_rs2_hit  = id_rs2_used_i && (id_rs2_addr_i == ex_rd_addr_i);
  // x0 never carries a real dependency
  assign load_use_o = ex_load_i && (ex_rd_addr_i != 5'd0) && (w_rs1_hit || w_rs2_hit);

endmodule
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl
// Description : RV32I 5-stage hazard/stall controller with bus timeout.
//               Optional PIPE_CTRL_PERF_EN adds stall/flush event counters.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int BUS_TIMEOUT = 16,
  parameter int TO_W        = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  pipe_ctrl_if.slave  bus
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o
`endif
);

  localparam logic [TO_W-1:0] c_TIMEOUT = TO_W'(BUS_TIMEOUT);

  logic [1:0]      r_state;
  logic [TO_W-1:0] r_cnt;
  logic [1:0]      w_next_state;
  logic [TO_W-1:0] w_next_cnt;
  hold_t           w_hold;
  logic            w_flush_if_id;
  logic            w_flush_id_ex;
  logic            w_redirect;
  logic            w_bus_err;
  logic            w_load_use;

  hazard_det u_hazard_det (
    .ex_load_i     (bus.ex_load_i),
    .ex_rd_addr_i  (bus.ex_rd_addr_i),
    .id_rs1_addr_i (bus.id_rs1_addr_i),
    .id_rs2_addr_i (bus.id_rs2_addr_i),
    .id_rs1_used_i (bus.id_rs1_used_i),
    .id_rs2_used_i (bus.id_rs2_used_i),
    .load_use_o    (w_load_use)
  );

  always_comb begin
    w_next_state  = r_state;
    w_next_cnt    = r_cnt;
    w_hold        = all_hold(1'b0);
    w_flush_if_id = 1'b0;
    w_flush_id_ex = 1'b0;
    w_redirect    = 1'b0;
    w_bus_err     = 1'b0;
    case (r_state)
      STATE_RUN: begin
        w_next_cnt = '0;
        if (bus.mem_busy_i) begin
          w_hold       = all_hold(1'b1);
          w_next_state = STATE_BUS_WAIT;
          w_next_cnt   = TO_W'(1);
        end else if (bus.jump_en_i) begin
          w_redirect    = 1'b1;
          w_flush_if_id = 1'b1;
          w_flush_id_ex = 1'b1;
        end else if (bus.md_start_i) begin
          w_hold       = all_hold(1'b1);
          w_next_state = STATE_MD_WAIT;
        end else if (w_load_use) begin
          w_hold.pc     = 1'b1;
          w_hold.if_id  = 1'b1;
          w_flush_id_ex = 1'b1;
        end
      end
      STATE_MD_WAIT: begin
        if (bus.md_done_i) begin
          w_next_state = STATE_RUN;
        end else begin
          w_hold = all_hold(1'b1);
        end
      end
      STATE_BUS_WAIT: begin
        if (!bus.mem_busy_i) begin
          w_next_state = STATE_RUN;
          w_next_cnt   = '0;
        end else if (r_cnt == c_TIMEOUT) begin
          w_bus_err    = 1'b1;
          w_next_state = STATE_RUN;
          w_next_cnt   = '0;
        end else begin
          w_hold     = all_hold(1'b1);
          w_next_cnt = r_cnt + TO_W'(1);
        end
      end
      default: begin
        w_next_state = STATE_RUN;
        w_next_cnt   = '0;
      end
    endcase
  end

  // Controls are forced quiet while reset is asserted, whatever the state
  assign bus.hold_pc_o       = rst_n & w_hold.pc;
  assign bus.hold_if_id_o    = rst_n & w_hold.if_id;
  assign bus.hold_id_ex_o    = rst_n & w_hold.id_ex;
  assign bus.flush_if_id_o   = rst_n & w_flush_if_id;
  assign bus.flush_id_ex_o   = rst_n & w_flush_id_ex;
  assign bus.redirect_en_o   = rst_n & w_redirect;
  assign bus.redirect_addr_o = (rst_n & w_redirect) ? bus.jump_addr_i : 32'h0;
  assign bus.bus_err_o       = rst_n & w_bus_err;
  assign bus.state_o         = r_state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= STATE_RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stall_cnt <= 32'h0;
      r_flush_cnt <= 32'h0;
    end else begin
      if (rst_n & w_hold.pc)      r_stall_cnt <= r_stall_cnt + 32'h1;
      if (rst_n & w_flush_if_id)  r_flush_cnt <= r_flush_cnt + 32'h1;
    end
  end

  assign stall_cnt_o = r_stall_cnt;
  assign flush_cnt_o = r_flush_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_ctrl
// Description : Vector table plus multi-cycle sequences for pipe_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  pipe_ctrl_if u_if ();

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
`endif

  pipe_ctrl #(.BUS_TIMEOUT(16), .TO_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .stall_cnt_o (stall_cnt),
    .flush_cnt_o (flush_cnt)
`endif
  );

  typedef struct packed {
    logic        rstn;
    logic        jump;
    logic [31:0] jaddr;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        u1;
    logic        u2;
    logic        ld;
    logic [4:0]  rd;
    logic        busy;
    logic        mds;
    logic        mdd;
  } in_t;

  typedef struct packed {
    logic        hpc;
    logic        hif;
    logic        hie;
    logic        fif;
    logic        fie;
    logic        ren;
    logic [31:0] raddr;
    logic        berr;
    logic [1:0]  st;
  } exp_t;

  typedef struct {
    string name;
    in_t   in;
    exp_t  ex;
  } vec_t;

  typedef struct {
    string name;
    exp_t  ex;
  } sb_t;

  sb_t  sb[$];
  int   total = 0;
  int   bad   = 0;
  vec_t vt[11];

  function automatic in_t mk_in(input int jump, input int ja, input int rs1, input int rs2,
                                input int u1, input int u2, input int ld, input int rd,
                                input int busy, input int mds, input int mdd);
    in_t r;
    r.rstn  = 1'b1;
    r.jump  = 1'(jump);
    r.jaddr = 32'(ja);
    r.rs1   = 5'(rs1);
    r.rs2   = 5'(rs2);
    r.u1    = 1'(u1);
    r.u2    = 1'(u2);
    r.ld    = 1'(ld);
    r.rd    = 5'(rd);
    r.busy  = 1'(busy);
    r.mds   = 1'(mds);
    r.mdd   = 1'(mdd);
    return r;
  endfunction

  function automatic exp_t mk_ex(input int hpc, input int hif, input int hie, input int fif,
                                 input int fie, input int ren, input int ra, input int berr,
                                 input int st);
    exp_t r;
    r.hpc   = 1'(hpc);
    r.hif   = 1'(hif);
    r.hie   = 1'(hie);
    r.fif   = 1'(fif);
    r.fie   = 1'(fie);
    r.ren   = 1'(ren);
    r.raddr = 32'(ra);
    r.berr  = 1'(berr);
    r.st    = 2'(st);
    return r;
  endfunction

  function automatic exp_t zero(input int st);
    return mk_ex(0, 0, 0, 0, 0, 0, 0, 0, st);
  endfunction

  function automatic exp_t hold3(input int st);
    return mk_ex(1, 1, 1, 0, 0, 0, 0, 0, st);
  endfunction

  function automatic exp_t stall1();
    return mk_ex(1, 1, 0, 0, 1, 0, 0, 0, 0);
  endfunction

  function automatic exp_t jmp(input int ra, input int st);
    return mk_ex(0, 0, 0, 1, 1, 1, ra, 0, st);
  endfunction

  task automatic drive(input in_t v);
    rst_n               = v.rstn;
    u_if.jump_en_i      = v.jump;
    u_if.jump_addr_i    = v.jaddr;
    u_if.id_rs1_addr_i  = v.rs1;
    u_if.id_rs2_addr_i  = v.rs2;
    u_if.id_rs1_used_i  = v.u1;
    u_if.id_rs2_used_i  = v.u2;
    u_if.ex_load_i      = v.ld;
    u_if.ex_rd_addr_i   = v.rd;
    u_if.mem_busy_i     = v.busy;
    u_if.md_start_i     = v.mds;
    u_if.md_done_i      = v.mdd;
  endtask

  task automatic check();
    sb_t  s;
    exp_t a;
    s = sb.pop_front();
    a = {u_if.hold_pc_o, u_if.hold_if_id_o, u_if.hold_id_ex_o, u_if.flush_if_id_o,
         u_if.flush_id_ex_o, u_if.redirect_en_o, u_if.redirect_addr_o, u_if.bus_err_o,
         u_if.state_o};
    total++;
    if (a !== s.ex) begin
      bad++;
      $display("FAIL %s: got hpc/hif/hie/fif/fie/ren=%b%b%b%b%b%b addr=%h err=%b st=%0d, want %b%b%b%b%b%b addr=%h err=%b st=%0d",
               s.name, a.hpc, a.hif, a.hie, a.fif, a.fie, a.ren, a.raddr, a.berr, a.st,
               s.ex.hpc, s.ex.hif, s.ex.hie, s.ex.fif, s.ex.fie, s.ex.ren, s.ex.raddr,
               s.ex.berr, s.ex.st);
    end
  endtask

  // Drive just after the edge, sample mid-cycle before the next edge
  task automatic cyc(input string nm, input in_t v, input exp_t e);
    @(posedge clk);
    #1;
    drive(v);
    sb.push_back('{name: nm, ex: e});
    #3;
    check();
  endtask

  initial begin
    in_t idle;
    in_t v;
    idle = mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset for two edges with the bus busy
    v = mk_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    v.rstn = 1'b0;
    drive(v);
    @(posedge clk);
    cyc("reset", v, zero(0));
    cyc("idle_after_reset", idle, zero(0));

    //           name            jump  ja          rs1 rs2 u1 u2 ld rd busy mds mdd
    vt[0]  = '{"lu_rs2",       mk_in(0, 0,          0,  5,  0, 1, 1, 5, 0, 0, 0), stall1()};
    vt[1]  = '{"lu_clears",    idle,                                             zero(0)};
    vt[2]  = '{"lu_rd0",       mk_in(0, 0,          0,  0,  0, 1, 1, 0, 0, 0, 0), zero(0)};
    vt[3]  = '{"lu_rs1",       mk_in(0, 0,          7,  0,  1, 0, 1, 7, 0, 0, 0), stall1()};
    vt[4]  = '{"lu_unused",    mk_in(0, 0,          7,  7,  0, 0, 1, 7, 0, 0, 0), zero(0)};
    vt[5]  = '{"no_load",      mk_in(0, 0,          7,  7,  1, 1, 0, 7, 0, 0, 0), zero(0)};
    vt[6]  = '{"lu_mismatch",  mk_in(0, 0,          6,  8,  1, 1, 1, 7, 0, 0, 0), zero(0)};
    vt[7]  = '{"jump_lu",      mk_in(1, 'h80,       0,  5,  0, 1, 1, 5, 0, 0, 0), jmp('h80, 0)};
    vt[8]  = '{"jump_md",      mk_in(1, 'h12345678, 0,  0,  0, 0, 0, 0, 0, 1, 0), jmp('h12345678, 0)};
    vt[9]  = '{"md_done_run",  mk_in(0, 0,          0,  0,  0, 0, 0, 0, 0, 0, 1), zero(0)};
    vt[10] = '{"idle",         idle,                                             zero(0)};
    for (int i = 0; i < 11; i++) cyc(vt[i].name, vt[i].in, vt[i].ex);

    // Mul/div wait: start at cycle 0, done at cycle 4
    cyc("md_c0", mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), hold3(0));
    cyc("md_c1", idle, hold3(1));
    cyc("md_c2_ignore", mk_in(1, 'h40, 0, 0, 0, 0, 0, 0, 1, 0, 0), hold3(1));
    cyc("md_c3", mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), hold3(1));
    cyc("md_c4_done", mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), zero(1));
    cyc("md_c5", idle, zero(0));

    // Bus timeout: 16 held cycles, then a lone error pulse with holds low
    v = mk_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    cyc("bt_c0", v, hold3(0));
    for (int i = 1; i < 16; i++) cyc($sformatf("bt_c%0d", i), v, hold3(2));
    cyc("bt_err", v, mk_ex(0, 0, 0, 0, 0, 0, 0, 1, 2));
    cyc("bt_after", idle, zero(0));

    // Bus release with a pending jump serviced in the first RUN cycle
    v = mk_in(1, 'h100, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    cyc("br_c0", v, hold3(0));
    cyc("br_c1", v, hold3(2));
    cyc("br_c2", v, hold3(2));
    cyc("br_release", mk_in(1, 'h100, 0, 0, 0, 0, 0, 0, 0, 0, 0), zero(2));
    cyc("br_jump", mk_in(1, 'h100, 0, 0, 0, 0, 0, 0, 0, 0, 0), jmp('h100, 0));
    cyc("br_idle", idle, zero(0));

    // Reset in the middle of MD_WAIT and BUS_WAIT
    cyc("mw_start", mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), hold3(0));
    cyc("mw_wait", idle, hold3(1));
    v = idle;
    v.rstn = 1'b0;
    cyc("mw_rst", v, zero(1));
    cyc("mw_run", idle, zero(0));
    v = mk_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    cyc("bw_start", v, hold3(0));
    v.rstn = 1'b0;
    cyc("bw_rst", v, zero(2));
    v.rstn = 1'b1;
    cyc("bw_rebusy", v, hold3(0));
    cyc("bw_release", idle, zero(2));
    cyc("bw_idle", idle, zero(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Pipeline hazard and stall controller for the 5-stage RV32I core.
- Takes redirect requests from EX, load-use information from ID and EX, busy status from the data-memory bus, and start/done from the multi-cycle mul/div unit.
- Drives the hold and flush controls of the PC, if_id and id_ex registers, plus the PC redirect.
- Holds a small FSM for multi-cycle waits and a bus-timeout counter.

Parameters:
- BUS_TIMEOUT, 16: BUS_WAIT cycles before bus_err_o fires (must be >=2).
- TO_W, 5: timeout counter width; must satisfy 2^TO_W > BUS_TIMEOUT.

Ports:
- clk  in  1  core clock
- rst_n  in  1  synchronous reset, active-low
- jump_en_i  in  1  EX requests redirect (branch taken, JAL, JALR)
- jump_addr_i  in  32  redirect target
- id_rs1_addr_i  in  5  ID source 1 address
- id_rs2_addr_i  in  5  ID source 2 address
- id_rs1_used_i  in  1  ID instruction reads rs1
- id_rs2_used_i  in  1  ID instruction reads rs2
- ex_load_i  in  1  EX instruction is a load
- ex_rd_addr_i  in  5  EX destination register
- mem_busy_i  in  1  data bus not ready this cycle
- md_start_i  in  1  EX issues mul/div
- md_done_i  in  1  mul/div result valid
- hold_pc_o  out  1  freeze PC
- hold_if_id_o  out  1  freeze if_id
- hold_id_ex_o  out  1  freeze id_ex
- flush_if_id_o  out  1  load NOP into if_id
- flush_id_ex_o  out  1  load NOP into id_ex
- redirect_en_o  out  1  PC takes redirect_addr_o
- redirect_addr_o  out  32  PC target
- bus_err_o  out  1  one-cycle timeout pulse
- state_o  out  2  FSM state, for debug

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state is RUN and the timeout counter is 0.
  - bus_err_o=0.
  - All hold, flush and redirect outputs are 0 while in RUN with idle inputs.
  - redirect_addr_o=0 whenever redirect_en_o=0.
- Reset applied mid-BUS_WAIT or mid-MD_WAIT returns to RUN on the next edge. Holds drop that cycle.
- States: RUN=0, MD_WAIT=1, BUS_WAIT=2. Encoding 3 is illegal and goes to RUN.
- Outputs are combinational from state and inputs, so they take effect in the same cycle. State and counter are registered.
- RUN, priority from highest to lowest:
  1. mem_busy_i=1: all three holds=1, no flush, no redirect. Next state BUS_WAIT; counter loads 1.
  2. jump_en_i=1: redirect_en_o=1, redirect_addr_o=jump_addr_i, flush_if_id_o=1, flush_id_ex_o=1, no holds. md_start_i is ignored that cycle.
  3. md_start_i=1: all holds=1. Next state MD_WAIT.
  4. Load-use: ex_load_i and ex_rd_addr_i!=0 and (rs1_used with rs1==rd, or rs2_used with rs2==rd). Response is hold_pc_o=1, hold_if_id_o=1, flush_id_ex_o=1 (one bubble). Stays in RUN; the condition clears by itself the next cycle.
- MD_WAIT:
  - While md_done_i=0: all holds=1.
  - Cycle with md_done_i=1: holds=0, next state RUN.
  - jump_en_i and mem_busy_i are ignored.
- BUS_WAIT:
  - While mem_busy_i=1 and counter<BUS_TIMEOUT: all holds=1 and the counter increments.
  - Cycle with mem_busy_i=0: holds=0, next state RUN, counter cleared.
  - Counter==BUS_TIMEOUT with mem_busy_i still 1: bus_err_o=1 for one cycle, holds=0, next state RUN, counter cleared.
- Jumps arriving during a wait are not latched. id_ex is held, so EX re-presents jump_en_i in the first RUN cycle and it is serviced then.
- md_done_i in RUN is ignored, as is md_start_i outside RUN.

Optional Feature:
- Macro: PIPE_CTRL_PERF_EN.
- With the macro defined, the block adds output ports stall_cnt_o[31:0] and flush_cnt_o[31:0].
  - stall_cnt_o increments on every cycle with hold_pc_o=1.
  - flush_cnt_o increments on every cycle with flush_if_id_o=1.
  - Both reset to 0 and wrap at 2^32.
- Without the macro, neither the ports nor the counters exist.

Decomposition:
- defines.v gains STATE_RUN, STATE_MD_WAIT and STATE_BUS_WAIT, plus the NOP encoding used by the flushes (ADDI x0,x0,0 = 32'h00000013).
- One sub-module: hazard_det, a combinational load-use comparator that outputs load_use_o.
- FSM, counter and output muxing stay in pipe_ctrl.

Test Plan:
- Reset: rst_n=0 for 2 cycles with mem_busy_i=1 → state_o=0, all outputs 0 after the edge.
- Load-use: ex_load_i=1, ex_rd=5, id_rs2=5, rs2_used=1 → one cycle of hold_pc, hold_if_id and flush_id_ex, then all 0.
- Load-use edge case: the same stimulus with ex_rd=0 → no stall.
- Jump plus load-use in the same cycle, jump_addr_i=32'h00000080 → redirect_en_o=1, addr 32'h80, both flushes, no holds.
- Mul/div: md_start_i at cycle 0, md_done_i at cycle 4 → holds 1 in cycles 0–3, 0 in cycle 4, state_o back to 0 in cycle 5.
- Bus timeout: mem_busy_i held 1 with BUS_TIMEOUT=16 → holds for 16 cycles, bus_err_o single pulse, holds 0 in that same cycle, state RUN.
- Bus release: mem_busy_i high 3 cycles with jump_en_i=1 throughout → no redirect while held; redirect_en_o=1 in the first RUN cycle.
